cpu_datapath: RTL and testbench



---
 rtl/cpu_datapath_pkg.sv | 48 ++++
 rtl/cpu_datapath_alu.sv | 51 +++++
 rtl/cpu_datapath.sv | 143 ++++++++++++++
 tb/tb_cpu_datapath.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_datapath_pkg.sv
// Shared constants for the basic-computer datapath: bus source codes, opcodes,
// strobe bit positions and register-reference instruction bit indices.
// No logic lives here; everything is compile-time constant.
package cpu_datapath_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 16;

    // Common-bus source select; the value is the index of the winning x[] bit.
    typedef enum logic [2:0] {
        SEL_NONE = 3'd0,
        SEL_AR   = 3'd1,
        SEL_PC   = 3'd2,
        SEL_DR   = 3'd3,
        SEL_AC   = 3'd4,
        SEL_IR   = 3'd5,
        SEL_TR   = 3'd6,
        SEL_MEM  = 3'd7
    } bus_sel_e;

    // Memory-reference opcodes in ir[14:12]; OP_REG marks register-reference.
    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_LDA = 3'd2;
    localparam logic [2:0] OP_REG = 3'd7;

    // ld bit positions: {AR,PC,DR,AC,IR}.
    localparam int LD_AR = 4;
    localparam int LD_PC = 3;
    localparam int LD_DR = 2;
    localparam int LD_AC = 1;
    localparam int LD_IR = 0;

    // inr/clr bit positions: {AR,PC,DR,AC}.
    localparam int IC_AR = 3;
    localparam int IC_PC = 2;
    localparam int IC_DR = 1;
    localparam int IC_AC = 0;

    // Register-reference instruction bits. CLA and INC reach the datapath as
    // clr/inr AC strobes rather than through the ALU.
    localparam int RR_CLA = 11;
    localparam int RR_CMA = 9;
    localparam int RR_CIR = 7;
    localparam int RR_CIL = 6;
    localparam int RR_INC = 5;

endpackage

// File: rtl/cpu_datapath_alu.sv
// Purpose: AC/E next-value logic for an AC load, chosen by the IR opcode.
// Latency: purely combinational, no state.
// Backpressure: none; result is only consumed when the AC load strobe is set.
// Ports: ac, dr, ir, e in; ac_next, e_next out.
module cpu_alu
    import cpu_datapath_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] ac,
    input  logic [DATA_W-1:0] dr,
    input  logic [DATA_W-1:0] ir,
    input  logic              e,
    output logic [DATA_W-1:0] ac_next,
    output logic              e_next
);

    logic [2:0]      opcode;
    logic [DATA_W:0] sum;

    assign opcode = ir[DATA_W-2 -: 3];
    assign sum    = {1'b0, ac} + {1'b0, dr};

    always_comb begin
        ac_next = ac;
        e_next  = e;
        case (opcode)
            OP_AND: ac_next = ac & dr;
            OP_ADD: {e_next, ac_next} = sum;
            OP_LDA: ac_next = dr;
            OP_REG: begin
                // First matching bit wins; none set leaves AC and E untouched.
                if (ir[RR_CMA]) begin
                    ac_next = ~ac;
                end else if (ir[RR_CIR]) begin
                    ac_next = {e, ac[DATA_W-1:1]};
                    e_next  = ac[0];
                end else if (ir[RR_CIL]) begin
                    ac_next = {ac[DATA_W-2:0], e};
                    e_next  = ac[DATA_W-1];
                end
            end
            default: ;
        endcase
    end

    // Indirect bit and the CLA/INC/other reg-ref bits are decoded elsewhere.
    logic unused_ir;
    assign unused_ir = ^{ir[DATA_W-1], ir[RR_CLA:RR_CMA+1], ir[RR_CIR+1], ir[RR_INC:0]};

endmodule

// File: rtl/cpu_datapath.sv
// Purpose: AR/PC/DR/AC/IR/E registers plus common-bus mux, driven by control strobes.
// Latency: registers update on the clock edge; bus and mem_* are combinational.
// Backpressure: none; every strobe is honoured in the cycle it is asserted.
// Ports: clk, reset, ld/inr/clr/x strobes, Read/Write, mem_rdata in;
//        mem_addr/wdata/we/re, ar, pc, dr, ac, ir, e, bus, bus_conflict out.
module cpu_datapath
    import cpu_datapath_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        ld,
    input  logic [3:0]        inr,
    input  logic [3:0]        clr,
    input  logic [7:0]        x,
    input  logic              Read,
    input  logic              Write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] ar,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] dr,
    output logic [DATA_W-1:0] ac,
    output logic [DATA_W-1:0] ir,
    output logic              e,
    output logic [DATA_W-1:0] bus,
    output logic              bus_conflict
);

    logic [ADDR_W-1:0] ar_q, ar_d, pc_q, pc_d;
    logic [DATA_W-1:0] dr_q, dr_d, ac_q, ac_d, ir_q, ir_d;
    logic              e_q, e_d;
    bus_sel_e          bus_sel;
    logic [DATA_W-1:0] alu_ac;
    logic              alu_e;

    // Priority encoder: the highest set source in x[7:1] owns the bus.
    always_comb begin
        bus_sel = SEL_NONE;
        for (int i = 1; i <= 7; i++) begin
            if (x[i]) bus_sel = bus_sel_e'(i[2:0]);
        end
    end

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign bus_conflict = |(x[7:1] & (x[7:1] - 7'd1));

    always_comb begin
        bus = '0;
        case (bus_sel)
            SEL_AR:  bus = {{(DATA_W-ADDR_W){1'b0}}, ar_q};
            SEL_PC:  bus = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
            SEL_DR:  bus = dr_q;
            SEL_AC:  bus = ac_q;
            SEL_IR:  bus = ir_q;
            SEL_MEM: bus = mem_rdata;
            default: bus = '0;  // SEL_NONE and SEL_TR both drive zero
        endcase
    end

    cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .ac      (ac_q),
        .dr      (dr_q),
        .ir      (ir_q),
        .e       (e_q),
        .ac_next (alu_ac),
        .e_next  (alu_e)
    );

    // Per register: clear beats load beats increment beats hold.
    always_comb begin
        ar_d = ar_q;
        pc_d = pc_q;
        dr_d = dr_q;
        ac_d = ac_q;
        ir_d = ir_q;
        e_d  = e_q;

        if (clr[IC_AR])      ar_d = '0;
        else if (ld[LD_AR])  ar_d = bus[ADDR_W-1:0];
        else if (inr[IC_AR]) ar_d = ar_q + ADDR_W'(1);

        if (clr[IC_PC])      pc_d = '0;
        else if (ld[LD_PC])  pc_d = bus[ADDR_W-1:0];
        else if (inr[IC_PC]) pc_d = pc_q + ADDR_W'(1);

        if (clr[IC_DR])      dr_d = '0;
        else if (ld[LD_DR])  dr_d = bus;
        else if (inr[IC_DR]) dr_d = dr_q + DATA_W'(1);

        // E only moves with an ALU load of AC; CLA/INC leave it alone.
        if (clr[IC_AC]) begin
            ac_d = '0;
        end else if (ld[LD_AC]) begin
            ac_d = alu_ac;
            e_d  = alu_e;
        end else if (inr[IC_AC]) begin
            ac_d = ac_q + DATA_W'(1);
        end

        if (ld[LD_IR]) ir_d = bus;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ar_q <= '0;
            pc_q <= '0;
            dr_q <= '0;
            ac_q <= '0;
            ir_q <= '0;
            e_q  <= 1'b0;
        end else begin
            ar_q <= ar_d;
            pc_q <= pc_d;
            dr_q <= dr_d;
            ac_q <= ac_d;
            ir_q <= ir_d;
            e_q  <= e_d;
        end
    end

    // Memory sees the current AR, so a same-cycle AR load affects the next access.
    assign mem_addr  = ar_q;
    assign mem_wdata = bus;
    assign mem_we    = Write;
    assign mem_re    = Read;

    assign ar = ar_q;
    assign pc = pc_q;
    assign dr = dr_q;
    assign ac = ac_q;
    assign ir = ir_q;
    assign e  = e_q;

    logic unused_x0;
    assign unused_x0 = x[0];

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed and random stimulus for cpu_datapath against an arithmetic reference model.
// Inputs change on the falling edge; outputs are sampled 1 time unit after an edge.
module tb_cpu_datapath;

    localparam int AW = 12;
    localparam int DW = 16;

    logic          clk;
    logic          reset;
    logic [4:0]    ld;
    logic [3:0]    inr;
    logic [3:0]    clr;
    logic [7:0]    x;
    logic          Read;
    logic          Write;
    logic [DW-1:0] mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_re;
    logic [AW-1:0] ar;
    logic [AW-1:0] pc;
    logic [DW-1:0] dr;
    logic [DW-1:0] ac;
    logic [DW-1:0] ir;
    logic          e;
    logic [DW-1:0] bus;
    logic          bus_conflict;

    // Asynchronous-read memory; the override lets the bench place any value on the bus.
    logic [DW-1:0] mem [4096];
    logic          use_ovr;
    logic [DW-1:0] ovr_val;
    assign mem_rdata = use_ovr ? ovr_val : mem[mem_addr];

    cpu_datapath #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .ld           (ld),
        .inr          (inr),
        .clr          (clr),
        .x            (x),
        .Read         (Read),
        .Write        (Write),
        .mem_rdata    (mem_rdata),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_re       (mem_re),
        .ar           (ar),
        .pc           (pc),
        .dr           (dr),
        .ac           (ac),
        .ir           (ir),
        .e            (e),
        .bus          (bus),
        .bus_conflict (bus_conflict)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec;
    int n_err;
    int m_ar, m_pc, m_dr, m_ac, m_ir, m_e, m_bus, m_conf;
    bit m_known;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int mem_at(input int a);
        return use_ovr ? int'(ovr_val) : int'(mem[a]);
    endfunction

    // Bus owner is the highest-numbered requesting source among x[7:1].
    task automatic model_bus();
        int s;
        int cnt;
        s = 0;
        cnt = 0;
        for (int i = 7; i >= 1; i--) begin
            if (x[i]) begin
                cnt++;
                if (s == 0) s = i;
            end
        end
        case (s)
            1: m_bus = m_ar;
            2: m_bus = m_pc;
            3: m_bus = m_dr;
            4: m_bus = m_ac;
            5: m_bus = m_ir;
            7: m_bus = mem_at(m_ar);
            default: m_bus = 0;
        endcase
        m_conf = (cnt > 1) ? 1 : 0;
    endtask

    task automatic drive(input logic r, input logic [4:0] l, input logic [3:0] in_v,
                         input logic [3:0] c, input logic [7:0] xv, input logic rd, input logic wr);
        @(negedge clk);
        reset = r;
        ld    = l;
        inr   = in_v;
        clr   = c;
        x     = xv;
        Read  = rd;
        Write = wr;
        #1;
        model_bus();
        if (m_known) begin
            chk("bus", bus, m_bus);
            chk("bus_conflict", bus_conflict, m_conf);
            chk("mem_addr", mem_addr, m_ar);
            chk("mem_wdata", mem_wdata, m_bus);
        end
        chk("mem_we", mem_we, wr);
        chk("mem_re", mem_re, rd);
    endtask

    task automatic clock();
        int n_ar = m_ar;
        int n_pc = m_pc;
        int n_dr = m_dr;
        int n_ac = m_ac;
        int n_ir = m_ir;
        int n_e  = m_e;
        int v;
        if (reset) begin
            n_ar = 0; n_pc = 0; n_dr = 0; n_ac = 0; n_ir = 0; n_e = 0;
        end else begin
            if (clr[3])      n_ar = 0;
            else if (ld[4])  n_ar = m_bus % 4096;
            else if (inr[3]) n_ar = (m_ar + 1) % 4096;

            if (clr[2])      n_pc = 0;
            else if (ld[3])  n_pc = m_bus % 4096;
            else if (inr[2]) n_pc = (m_pc + 1) % 4096;

            if (clr[1])      n_dr = 0;
            else if (ld[2])  n_dr = m_bus;
            else if (inr[1]) n_dr = (m_dr + 1) % 65536;

            if (ld[0]) n_ir = m_bus;

            if (clr[0]) begin
                n_ac = 0;
            end else if (ld[1]) begin
                v = m_e * 65536 + m_ac;  // 17-bit {E,AC}
                case ((m_ir / 4096) % 8)
                    0: n_ac = m_ac & m_dr;
                    1: begin
                        v = m_ac + m_dr;
                        n_ac = v % 65536;
                        n_e  = v / 65536;
                    end
                    2: n_ac = m_dr;
                    7: begin
                        if (m_ir[9]) begin
                            n_ac = 65535 - m_ac;
                        end else if (m_ir[7]) begin
                            v = (v >> 1) | ((v % 2) << 16);
                            n_ac = v % 65536;
                            n_e  = v / 65536;
                        end else if (m_ir[6]) begin
                            v = ((v << 1) | (v >> 16)) % 131072;
                            n_ac = v % 65536;
                            n_e  = v / 65536;
                        end
                    end
                    default: ;
                endcase
            end else if (inr[0]) begin
                n_ac = (m_ac + 1) % 65536;
            end
        end
        @(posedge clk);
        #1;
        m_ar = n_ar; m_pc = n_pc; m_dr = n_dr; m_ac = n_ac; m_ir = n_ir; m_e = n_e;
        m_known = 1'b1;
        chk("ar", ar, m_ar);
        chk("pc", pc, m_pc);
        chk("dr", dr, m_dr);
        chk("ac", ac, m_ac);
        chk("ir", ir, m_ir);
        chk("e", e, m_e);
    endtask

    // Put a value on the bus from memory and load it into the registers in lmask.
    task automatic put(input logic [15:0] v, input logic [4:0] lmask);
        use_ovr = 1'b1;
        ovr_val = v;
        drive(1'b0, lmask, 4'h0, 4'h0, 8'h80, 1'b0, 1'b0);
        clock();
        use_ovr = 1'b0;
    endtask

    task automatic ldac();
        drive(1'b0, 5'b00010, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0);
        clock();
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        m_ar = 0; m_pc = 0; m_dr = 0; m_ac = 0; m_ir = 0; m_e = 0;
        m_bus = 0; m_conf = 0; m_known = 1'b0;
        use_ovr = 1'b0; ovr_val = '0;
        reset = 1'b1; ld = '0; inr = '0; clr = '0; x = '0; Read = 1'b0; Write = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);

        // 1: reset wins over every strobe
        drive(1'b1, 5'h1F, 4'hF, 4'hF, 8'hFF, 1'b1, 1'b1);
        clock();
        chk("rst_ar", ar, 0); chk("rst_pc", pc, 0); chk("rst_dr", dr, 0);
        chk("rst_ac", ac, 0); chk("rst_ir", ir, 0); chk("rst_e", e, 0);
        drive(1'b0, 5'h00, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0);
        chk("rst_bus", bus, 0);
        clock();

        // 2: fetch sequence
        put(16'h0010, 5'b01000);
        drive(1'b0, 5'b10000, 4'h0, 4'h0, 8'h04, 1'b0, 1'b0);
        clock();
        chk("t2_ar", ar, 12'h010);
        mem[12'h010] = 16'h1234;
        drive(1'b0, 5'b00001, 4'b0100, 4'h0, 8'h80, 1'b1, 1'b0);
        chk("t2_bus_mem", bus, 16'h1234);
        clock();
        chk("t2_ir", ir, 16'h1234);
        chk("t2_pc", pc, 12'h011);

        // 3: ADD with carry out, then AND
        put(16'h2000, 5'b00001);
        put(16'hFFFF, 5'b00100);
        ldac();
        chk("t3_lda", ac, 16'hFFFF);
        put(16'h0001, 5'b00100);
        put(16'h1000, 5'b00001);
        ldac();
        chk("t3_add_ac", ac, 16'h0000);
        chk("t3_add_e", e, 1);
        put(16'h0000, 5'b00001);
        put(16'h00F0, 5'b00100);
        ldac();
        chk("t3_and_ac", ac, 16'h0000);
        chk("t3_and_e", e, 1);

        // 4: circulate right then left through E
        put(16'h2000, 5'b00001);
        put(16'h0003, 5'b00100);
        ldac();
        chk("t4_ac_init", ac, 16'h0003);
        put(16'h7080, 5'b00001);
        ldac();
        chk("t4_cir_ac", ac, 16'h8001);
        chk("t4_cir_e", e, 1);
        put(16'h7040, 5'b00001);
        ldac();
        chk("t4_cil_ac", ac, 16'h0003);
        chk("t4_cil_e", e, 1);

        // 5: clear priority and increment wrap
        put(16'h0042, 5'b00100);
        put(16'h2000, 5'b00001);
        ldac();
        chk("t5_ac42", ac, 16'h0042);
        drive(1'b0, 5'b00010, 4'b0001, 4'b0001, 8'h00, 1'b0, 1'b0);
        clock();
        chk("t5_clr_wins", ac, 16'h0000);
        chk("t5_clr_e", e, 1);
        put(16'h0FFF, 5'b01000);
        drive(1'b0, 5'h00, 4'b0100, 4'h0, 8'h00, 1'b0, 1'b0);
        clock();
        chk("t5_pc_wrap", pc, 12'h000);
        put(16'h0FFF, 5'b10000);
        drive(1'b0, 5'h00, 4'b1000, 4'h0, 8'h00, 1'b0, 1'b0);
        clock();
        chk("t5_ar_wrap", ar, 12'h000);
        put(16'hFFFF, 5'b00100);
        drive(1'b0, 5'h00, 4'b0010, 4'h0, 8'h00, 1'b0, 1'b0);
        clock();
        chk("t5_dr_wrap", dr, 16'h0000);
        put(16'h0005, 5'b00100);
        drive(1'b0, 5'b00010, 4'b0001, 4'h0, 8'h00, 1'b0, 1'b0);
        clock();
        chk("t5_ld_beats_inr", ac, 16'h0005);

        // 6: bus conflicts, empty bus, TR, write path
        use_ovr = 1'b1;
        ovr_val = 16'hBEEF;
        drive(1'b0, 5'h00, 4'h0, 4'h0, 8'h90, 1'b0, 1'b0);
        chk("t6_conf_bus", bus, 16'hBEEF);
        chk("t6_conf_flag", bus_conflict, 1);
        clock();
        use_ovr = 1'b0;
        drive(1'b0, 5'h00, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0);
        chk("t6_idle_bus", bus, 0);
        chk("t6_idle_flag", bus_conflict, 0);
        clock();
        drive(1'b0, 5'h00, 4'h0, 4'h0, 8'h40, 1'b0, 1'b0);
        chk("t6_tr_bus", bus, 0);
        clock();
        drive(1'b0, 5'b10000, 4'h0, 4'h0, 8'h10, 1'b0, 1'b1);
        chk("t6_we", mem_we, 1);
        chk("t6_wdata", mem_wdata, 16'h0005);
        chk("t6_old_ar", mem_addr, 12'h000);
        clock();
        chk("t6_ar_loaded", ar, 12'h005);
        drive(1'b0, 5'h00, 4'h0, 4'h0, 8'h00, 1'b1, 1'b1);
        chk("t6_rw_re", mem_re, 1);
        chk("t6_rw_we", mem_we, 1);
        clock();

        // Random phase
        for (int n = 0; n < 600; n++) begin
            logic       r;
            logic [7:0] xv;
            logic [3:0] in_v;
            logic [3:0] c;
            r = ($urandom_range(0, 63) == 0);
            case ($urandom_range(0, 3))
                0:       xv = 8'h00;
                3:       xv = 8'($urandom);
                default: xv = 8'(1 << $urandom_range(1, 7));
            endcase
            in_v = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            c    = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'h0;
            drive(r, 5'($urandom), in_v, c, xv, 1'($urandom), 1'($urandom));
            clock();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
